// File: rtl/dma_line_writer_pkg.sv
// rtl/dma_line_writer_pkg.sv - shared constants and state encoding for the DMA line writer
// Contents: default word/line geometry, write-hold latency, field widths and the FSM state type.
package dma_line_writer_pkg;

  localparam int DMA_WORD_SIZE     = 16;
  localparam int DMA_LINE_WORDS    = 4;
  localparam int DMA_WRITE_LATENCY = 2;
  localparam int DMA_LEN_WIDTH     = 16;
  localparam int DMA_ADDR_WIDTH    = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_FETCH = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } dma_state_t;

endpackage

// File: rtl/dma_line_buffer.sv
// rtl/dma_line_buffer.sv - captured device line plus write-hold down-counter
// Ports:
//   clk, reset_n  : clock and synchronous active-high reset
//   capture       : load dev_data and restart the hold counter
//   dev_data      : incoming device line
//   count_en      : write phase active, counter decrements
//   line_data     : captured line (drives the memory data bus)
//   done          : last cycle of the write hold
module dma_line_buffer
  import dma_line_writer_pkg::*;
#(
  parameter int LINE_WIDTH    = DMA_WORD_SIZE * DMA_LINE_WORDS,
  parameter int WRITE_LATENCY = DMA_WRITE_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  capture,
  input  logic [LINE_WIDTH-1:0] dev_data,
  input  logic                  count_en,
  output logic [LINE_WIDTH-1:0] line_data,
  output logic                  done
);

  localparam int CW = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;

  logic [LINE_WIDTH-1:0] line_q;
  logic [CW-1:0]         cnt_q;

  // Counter holds the number of write cycles still to come after the current one.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else if (capture) begin
      line_q <= dev_data;
      cnt_q  <= CW'(WRITE_LATENCY - 1);
    end else if (count_en && (cnt_q != '0)) begin
      cnt_q  <= cnt_q - CW'(1);
    end
  end

  assign line_data = line_q;
  assign done      = (cnt_q == '0);

endmodule

// File: rtl/dma_line_writer.sv
// rtl/dma_line_writer.sv - bus-master DMA engine writing device lines into line memory
// Ports:
//   clk, reset_n                     : clock and synchronous active-high reset
//   cmd_valid/cmd_addr/cmd_length    : CPU command (start word address, length in words)
//   cmd_ready                        : engine idle, command taken when cmd_valid
//   br / bg                          : bus request out, bus grant in
//   dev_valid/dev_data/dev_ready     : device line handshake
//   d_writeM/d_address/d_data        : memory line write port
//   irq                              : one-cycle completion pulse
module dma_line_writer
  import dma_line_writer_pkg::*;
#(
  parameter int WORD_SIZE     = DMA_WORD_SIZE,
  parameter int LINE_WORDS    = DMA_LINE_WORDS,
  parameter int WRITE_LATENCY = DMA_WRITE_LATENCY,
  parameter int LEN_WIDTH     = DMA_LEN_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             cmd_valid,
  input  logic [DMA_ADDR_WIDTH-1:0]        cmd_addr,
  input  logic [LEN_WIDTH-1:0]             cmd_length,
  output logic                             cmd_ready,
  output logic                             br,
  input  logic                             bg,
  input  logic                             dev_valid,
  input  logic [WORD_SIZE*LINE_WORDS-1:0]  dev_data,
  output logic                             dev_ready,
  output logic                             d_writeM,
  output logic [DMA_ADDR_WIDTH-1:0]        d_address,
  output logic [WORD_SIZE*LINE_WORDS-1:0]  d_data,
  output logic                             irq
);

  localparam int LINE_WIDTH = WORD_SIZE * LINE_WORDS;

  dma_state_t                  state_q, state_d;
  logic [DMA_ADDR_WIDTH-1:0]   addr_q;
  logic [DMA_ADDR_WIDTH-1:0]   d_address_q;
  logic [LEN_WIDTH:0]          lines_q;
  logic [LEN_WIDTH:0]          len_round;
  logic [LEN_WIDTH:0]          len_lines;
  logic                        capture;
  logic                        wr_done;

  // Round up to whole lines; one extra bit keeps 0xFFFF + 3 from overflowing.
  assign len_round = {1'b0, cmd_length} + (LEN_WIDTH+1)'(LINE_WORDS - 1);
  assign len_lines = len_round / (LEN_WIDTH+1)'(LINE_WORDS);

  assign capture = (state_q == ST_FETCH) && dev_valid;

  dma_line_buffer #(
    .LINE_WIDTH    (LINE_WIDTH),
    .WRITE_LATENCY (WRITE_LATENCY)
  ) u_buffer (
    .clk       (clk),
    .reset_n   (reset_n),
    .capture   (capture),
    .dev_data  (dev_data),
    .count_en  (state_q == ST_WRITE),
    .line_data (d_data),
    .done      (wr_done)
  );

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      lines_q     <= '0;
      d_address_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && cmd_valid) begin
        addr_q  <= cmd_addr;
        lines_q <= len_lines;
      end
      // Address output is snapshotted with the data so both hold across idle gaps.
      if (capture) begin
        d_address_q <= addr_q;
      end
      if ((state_q == ST_WRITE) && wr_done) begin
        addr_q  <= addr_q + DMA_ADDR_WIDTH'(LINE_WORDS);
        lines_q <= lines_q - (LEN_WIDTH+1)'(1);
      end
    end
  end

  assign d_address = d_address_q;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    br        = 1'b0;
    dev_ready = 1'b0;
    d_writeM  = 1'b0;
    irq       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = (len_lines == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        br = 1'b1;
        if (bg) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        br        = 1'b1;
        dev_ready = 1'b1;
        if (dev_valid) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        br       = 1'b1;
        d_writeM = 1'b1;
        if (wr_done) begin
          state_d = (lines_q == (LEN_WIDTH+1)'(1)) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        irq     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
